// File: rtl/fft_controller.sv
// fft_controller: sequencer for a 64-point radix-2 FFT, driving sample load,
// per-stage butterfly read/write pairs over ping-pong banks, and result output.
module fft_controller #(
    parameter int N_LEVELS = 6,
    parameter int N_BFLY   = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       sample_valid,
    input  logic       out_ready,
    output logic       load,
    output logic       processing,
    output logic       done,
    output logic [5:0] fft_level,
    output logic [5:0] butterfly_iter,
    output logic [5:0] load_address,
    output logic [5:0] out_address,
    output logic       we,
    output logic       bank_sel,
    output logic       out_valid,
    output logic       frame_done,
    output logic       busy
);
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] LOAD    = 3'd1;
    localparam logic [2:0] PROC_RD = 3'd2;
    localparam logic [2:0] PROC_WR = 3'd3;
    localparam logic [2:0] OUTPUT  = 3'd4;
    localparam logic [5:0] LAST_LVL = 6'(N_LEVELS - 1);
    localparam logic [5:0] LAST_BF  = 6'(N_BFLY - 1);

    logic [2:0] state;

    always_comb begin
        load       = state == LOAD;
        processing = state == PROC_RD || state == PROC_WR;
        done       = state == OUTPUT;
        we         = state == PROC_WR;
        busy       = state != IDLE;
        out_valid  = done;
    end

    // Counters leave their state at 0, so each phase starts from a clean index.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            fft_level      <= '0;
            butterfly_iter <= '0;
            load_address   <= '0;
            out_address    <= '0;
            bank_sel       <= 1'b0;
            frame_done     <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: if (start) state <= LOAD;
                LOAD: if (sample_valid) begin
                    load_address <= load_address + 6'd1;
                    if (load_address == 6'd63) state <= PROC_RD;
                end
                PROC_RD: state <= PROC_WR;
                PROC_WR: begin
                    state <= PROC_RD;
                    if (butterfly_iter == LAST_BF) begin
                        butterfly_iter <= '0;
                        bank_sel       <= ~bank_sel;
                        if (fft_level == LAST_LVL) begin
                            fft_level <= '0;
                            state     <= OUTPUT;
                        end else fft_level <= fft_level + 6'd1;
                    end else butterfly_iter <= butterfly_iter + 6'd1;
                end
                OUTPUT: if (out_ready) begin
                    out_address <= out_address + 6'd1;
                    if (out_address == 6'd63) begin
                        state      <= IDLE;
                        frame_done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fft_controller.sv
// tb_fft_controller: scoreboard bench for fft_controller frame sequencing.
module tb_fft_controller;
    logic clk = 1'b0, reset = 1'b1, start = 1'b0, sample_valid = 1'b0, out_ready = 1'b0;
    logic load, processing, done, we, bank_sel, out_valid, frame_done, busy;
    logic [5:0] fft_level, butterfly_iter, load_address, out_address;
    int vectors = 0, miscompares = 0;
    int exp_q[$];

    fft_controller dut (
        .clk(clk), .reset(reset), .start(start), .sample_valid(sample_valid),
        .out_ready(out_ready), .load(load), .processing(processing), .done(done),
        .fft_level(fft_level), .butterfly_iter(butterfly_iter),
        .load_address(load_address), .out_address(out_address), .we(we),
        .bank_sel(bank_sel), .out_valid(out_valid), .frame_done(frame_done), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] outs();
        return {load, processing, done, we, bank_sel, out_valid, frame_done, busy,
                fft_level, butterfly_iter, load_address, out_address};
    endfunction

    task automatic test_reset;
        #3;
        vectors++;
        if (outs() !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_async: outputs=%h expected 0", outs());
        end
        tick;
        vectors++;
        if (outs() !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_held: outputs=%h expected 0", outs());
        end
        reset = 1'b0;
        tick;
        vectors++;
        if (busy !== 1'b0 || load !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_no_start: busy=%b load=%b expected 0 0", busy, load);
        end
    endtask

    task automatic test_load(input bit stall);
        int nl = 0, cyc = 0;
        while (load === 1'b1 && cyc < 300) begin
            sample_valid = stall ? (cyc % 2 == 0) : 1'b1;
            vectors++;
            if (load_address !== 6'(nl) || busy !== 1'b1) begin
                miscompares++;
                $display("FAIL load_addr: cyc=%0d addr=%0d busy=%b expected %0d 1", cyc, load_address, busy, nl);
            end
            if (sample_valid) nl++;
            tick;
            cyc++;
        end
        sample_valid = 1'b0;
        vectors++;
        if (cyc !== (stall ? 127 : 64) || nl !== 64) begin
            miscompares++;
            $display("FAIL load_len: cycles=%0d valids=%0d expected %0d 64", cyc, nl, stall ? 127 : 64);
        end
        vectors++;
        if ({processing, we, fft_level, butterfly_iter, bank_sel, load_address} !== {2'b10, 6'd0, 6'd0, 1'b0, 6'd0}) begin
            miscompares++;
            $display("FAIL proc_entry: proc=%b we=%b lvl=%0d bf=%0d bank=%b la=%0d expected 1 0 0 0 0 0",
                     processing, we, fft_level, butterfly_iter, bank_sel, load_address);
        end
    endtask

    task automatic test_process;
        int cyc = 0;
        bit chk = 1'b0;
        logic pb = 1'b0;
        while (processing === 1'b1 && cyc < 1000) begin
            vectors++;
            if (we !== 1'(cyc % 2) || fft_level !== 6'(cyc / 64) || butterfly_iter !== 6'((cyc / 2) % 32)
                || bank_sel !== 1'((cyc / 64) % 2)) begin
                miscompares++;
                $display("FAIL proc_seq: cyc=%0d we=%b lvl=%0d bf=%0d bank=%b expected %0d %0d %0d %0d",
                         cyc, we, fft_level, butterfly_iter, bank_sel, cyc % 2, cyc / 64, (cyc / 2) % 32, (cyc / 64) % 2);
            end
            if (chk) begin
                vectors++;
                if ({fft_level, butterfly_iter, bank_sel, we} !== {6'd3, 6'd0, ~pb, 1'b0}) begin
                    miscompares++;
                    $display("FAIL stage_boundary: lvl=%0d bf=%0d bank=%b we=%b expected 3 0 %b 0",
                             fft_level, butterfly_iter, bank_sel, we, ~pb);
                end
                chk = 1'b0;
            end
            if (we && fft_level == 6'd2 && butterfly_iter == 6'd31) begin
                chk = 1'b1;
                pb = bank_sel;
            end
            tick;
            cyc++;
        end
        vectors++;
        if (cyc !== 384) begin
            miscompares++;
            $display("FAIL proc_len: cycles=%0d expected 384", cyc);
        end
    endtask

    task automatic test_output(input bit bp);
        int cyc = 0, stalls = 0;
        for (int i = 0; i < 64; i++) exp_q.push_back(i);
        vectors++;
        if ({done, bank_sel, fft_level, butterfly_iter, out_address} !== {2'b10, 18'd0}) begin
            miscompares++;
            $display("FAIL out_entry: done=%b bank=%b lvl=%0d bf=%0d oa=%0d expected 1 0 0 0 0",
                     done, bank_sel, fft_level, butterfly_iter, out_address);
        end
        while (done === 1'b1 && cyc < 300 && exp_q.size() > 0) begin
            out_ready = !(bp && out_address == 6'd10 && stalls < 5);
            vectors++;
            if (out_valid !== 1'b1 || frame_done !== 1'b0 || out_address !== 6'(exp_q[0])) begin
                miscompares++;
                $display("FAIL out_addr: cyc=%0d oa=%0d valid=%b fd=%b expected %0d 1 0",
                         cyc, out_address, out_valid, frame_done, exp_q[0]);
            end
            if (out_ready) void'(exp_q.pop_front());
            else stalls++;
            tick;
            cyc++;
        end
        out_ready = 1'b0;
        vectors++;
        if (cyc !== (bp ? 69 : 64) || exp_q.size() !== 0) begin
            miscompares++;
            $display("FAIL out_len: cycles=%0d left=%0d expected %0d 0", cyc, exp_q.size(), bp ? 69 : 64);
        end
        exp_q.delete();
        vectors++;
        if (frame_done !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || out_address !== 6'd0) begin
            miscompares++;
            $display("FAIL frame_end: fd=%b busy=%b done=%b oa=%0d expected 1 0 0 0", frame_done, busy, done, out_address);
        end
    endtask

    task automatic test_full_frame;
        start = 1'b1;
        tick;
        start = 1'b0;
        vectors++;
        if (load !== 1'b1 || load_address !== 6'd0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL start_load: load=%b la=%0d busy=%b expected 1 0 1", load, load_address, busy);
        end
        test_load(1'b0);
        test_process();
        test_output(1'b0);
        tick;
        vectors++;
        if (frame_done !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL after_frame: fd=%b busy=%b expected 0 0", frame_done, busy);
        end
    endtask

    task automatic test_stall_backpressure;
        start = 1'b1;
        tick;
        start = 1'b0;
        test_load(1'b1);
        test_process();
        test_output(1'b1);
        tick;
    endtask

    task automatic test_back_to_back;
        start = 1'b1;
        tick;
        test_load(1'b0);
        test_process();
        test_output(1'b0);
        tick;
        vectors++;
        if (load !== 1'b1 || load_address !== 6'd0 || frame_done !== 1'b0) begin
            miscompares++;
            $display("FAIL restart: load=%b la=%0d fd=%b expected 1 0 0", load, load_address, frame_done);
        end
        start = 1'b0;
    endtask

    task automatic test_async_reset;
        int cyc = 0;
        test_load(1'b0);
        while (!(we === 1'b1 && fft_level == 6'd4) && cyc < 1000) begin
            tick;
            cyc++;
        end
        vectors++;
        if (we !== 1'b1 || fft_level !== 6'd4) begin
            miscompares++;
            $display("FAIL reach_lvl4: we=%b lvl=%0d expected 1 4", we, fft_level);
        end
        #2 reset = 1'b1;
        #1;
        vectors++;
        if (outs() !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_midproc: outputs=%h expected 0", outs());
        end
        tick;
        reset = 1'b0;
        start = 1'b1;
        tick;
        start = 1'b0;
        vectors++;
        if (load !== 1'b1 || load_address !== 6'd0 || fft_level !== 6'd0 || bank_sel !== 1'b0) begin
            miscompares++;
            $display("FAIL fresh_load: load=%b la=%0d lvl=%0d bank=%b expected 1 0 0 0", load, load_address, fft_level, bank_sel);
        end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_stall_backpressure();
        test_back_to_back();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
